// File: rtl/tone_gen.sv
// tone_gen: request-driven phase-accumulator tone source.
// Three register stages (accumulate, shape, attenuate): one signed sample
// appears on sample_out, with a one-cycle sample_valid strobe, three cycles
// after each sample_req pulse.
module tone_gen #(
    parameter int unsigned PHASE_W  = 32,
    parameter int unsigned SAMPLE_W = 24
) (
    input  logic                sys_clk,
    input  logic                rst,
    input  logic                sample_req,
    input  logic                enable,
    input  logic [PHASE_W-1:0]  freq_word,
    input  logic [1:0]          wave_sel,
    input  logic [3:0]          volume,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                sample_valid
);

    typedef enum logic [1:0] {
        WAVE_SQUARE = 2'd0,
        WAVE_SAW    = 2'd1,
        WAVE_TRI    = 2'd2,
        WAVE_SILENT = 2'd3
    } wave_t;

    localparam logic [SAMPLE_W-1:0] SQ_POS  = {1'b0, {(SAMPLE_W-1){1'b1}}};
    localparam logic [SAMPLE_W-1:0] SQ_NEG  = {1'b1, {(SAMPLE_W-2){1'b0}}, 1'b1};
    localparam logic [SAMPLE_W-1:0] MSB_BIT = {1'b1, {(SAMPLE_W-1){1'b0}}};

    // ------------------------------------------------------------------
    // Stage 1: phase accumulator, shadow registers, request valid
    // ------------------------------------------------------------------
    logic [PHASE_W-1:0] phase_q,     phase_d;
    wave_t              wave_sh_q,   wave_sh_d;
    logic [3:0]         vol_sh_q,    vol_sh_d;
    logic               s1_valid_q,  s1_valid_d;
    wave_t              s1_wave_q,   s1_wave_d;
    logic [3:0]         s1_vol_q,    s1_vol_d;
    logic [PHASE_W:0]   phase_sum;

    // Stage-1 next state: advance phase on request, reload shadows on wrap
    // (or continuously while disabled), tag a disabled request as silent.
    always_comb begin
        phase_sum  = {1'b0, phase_q} + {1'b0, freq_word};
        phase_d    = phase_q;
        wave_sh_d  = wave_sh_q;
        vol_sh_d   = vol_sh_q;
        s1_valid_d = sample_req;
        s1_wave_d  = s1_wave_q;
        s1_vol_d   = s1_vol_q;

        if (!enable) begin
            phase_d   = '0;
            wave_sh_d = wave_t'(wave_sel);
            vol_sh_d  = volume;
            if (sample_req) begin
                s1_wave_d = WAVE_SILENT;
                s1_vol_d  = volume;
            end
        end else if (sample_req) begin
            phase_d = phase_sum[PHASE_W-1:0];
            if (phase_sum[PHASE_W]) begin
                wave_sh_d = wave_t'(wave_sel);
                vol_sh_d  = volume;
            end
            // The freshly loaded shadow values travel with the wrapped phase.
            s1_wave_d = wave_sh_d;
            s1_vol_d  = vol_sh_d;
        end
    end

    // Stage-1 registers with synchronous reset.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            phase_q    <= '0;
            wave_sh_q  <= WAVE_SILENT;
            vol_sh_q   <= '0;
            s1_valid_q <= 1'b0;
            s1_wave_q  <= WAVE_SILENT;
            s1_vol_q   <= '0;
        end else begin
            phase_q    <= phase_d;
            wave_sh_q  <= wave_sh_d;
            vol_sh_q   <= vol_sh_d;
            s1_valid_q <= s1_valid_d;
            s1_wave_q  <= s1_wave_d;
            s1_vol_q   <= s1_vol_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: waveform shaping from the top SAMPLE_W phase bits
    // ------------------------------------------------------------------
    logic [SAMPLE_W-1:0] t_top;
    logic                t_msb;
    logic [SAMPLE_W-2:0] t_low;
    logic [SAMPLE_W-2:0] tri_u;
    logic [SAMPLE_W-1:0] shaped;
    logic [SAMPLE_W-1:0] s2_sample_q, s2_sample_d;
    logic [3:0]          s2_vol_q,    s2_vol_d;
    logic                s2_valid_q,  s2_valid_d;

    // phase_q only changes on a request, so one cycle after a request it still
    // holds exactly the phase that request produced.
    always_comb begin
        t_top = phase_q[PHASE_W-1 -: SAMPLE_W];
        t_msb = t_top[SAMPLE_W-1];
        t_low = t_top[SAMPLE_W-2:0];
        tri_u = t_msb ? ~t_low : t_low;

        unique case (s1_wave_q)
            WAVE_SQUARE: shaped = t_msb ? SQ_NEG : SQ_POS;
            WAVE_SAW:    shaped = {~t_msb, t_low};
            WAVE_TRI:    shaped = {tri_u, 1'b0} ^ MSB_BIT;
            default:     shaped = '0;
        endcase

        s2_valid_d  = s1_valid_q;
        s2_sample_d = s2_sample_q;
        s2_vol_d    = s2_vol_q;
        if (s1_valid_q) begin
            s2_sample_d = shaped;
            s2_vol_d    = s1_vol_q;
        end
    end

    // Stage-2 registers with synchronous reset.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            s2_sample_q <= '0;
            s2_vol_q    <= '0;
            s2_valid_q  <= 1'b0;
        end else begin
            s2_sample_q <= s2_sample_d;
            s2_vol_q    <= s2_vol_d;
            s2_valid_q  <= s2_valid_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: volume attenuation and registered outputs
    // ------------------------------------------------------------------
    logic [SAMPLE_W-1:0] out_q, out_d;
    logic                valid_q, valid_d;

    // Arithmetic shift floors toward minus infinity, so -1 stays -1.
    always_comb begin
        valid_d = s2_valid_q;
        out_d   = out_q;
        if (s2_valid_q) begin
            out_d = $signed(s2_sample_q) >>> s2_vol_q;
        end
    end

    // Output registers with synchronous reset.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign sample_out   = out_q;
    assign sample_valid = valid_q;

endmodule

// File: tb/tb_tone_gen.sv
// Testbench for tone_gen: directed scenarios with known sample values plus a
// randomized run, all checked cycle by cycle against an arithmetic model.
module tb_tone_gen;

    logic        sys_clk = 1'b0;
    logic        rst;
    logic        sample_req;
    logic        enable;
    logic [31:0] freq_word;
    logic [1:0]  wave_sel;
    logic [3:0]  volume;
    logic [23:0] sample_out;
    logic        sample_valid;

    always #5 sys_clk = ~sys_clk;

    tone_gen #(.PHASE_W(32), .SAMPLE_W(24)) dut (
        .sys_clk      (sys_clk),
        .rst          (rst),
        .sample_req   (sample_req),
        .enable       (enable),
        .freq_word    (freq_word),
        .wave_sel     (wave_sel),
        .volume       (volume),
        .sample_out   (sample_out),
        .sample_valid (sample_valid)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        int          due;
        logic [23:0] val;
    } strobe_t;

    strobe_t     pend[$];
    longint      m_phase = 0;
    int          m_wsh   = 3;
    int          m_vsh   = 0;
    logic [23:0] m_out   = '0;

    logic [23:0] seen[$];
    int          seen_cyc[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Ideal waveform value for a 24-bit phase t, as a signed integer.
    function automatic longint shape(int w, longint t);
        longint half = 64'd1 << 23;
        case (w)
            0: return (t < half) ? (half - 1) : -(half - 1);
            1: return t - half;
            2: return (t < half) ? (2 * t - half) : (2 * ((64'd1 << 24) - 1 - t) - half);
            default: return 0;
        endcase
    endfunction

    // Division by 2^v rounded toward minus infinity.
    function automatic longint atten(longint x, int v);
        longint d = 64'd1 << v;
        if (x >= 0) return x / d;
        return -((-x + d - 1) / d);
    endfunction

    // Consume the inputs driven for the current cycle.
    task automatic model_apply();
        longint      sum;
        longint      v;
        strobe_t     s;
        logic [63:0] vb;
        if (rst) begin
            m_phase = 0;
            m_wsh   = 3;
            m_vsh   = 0;
            pend.delete();
            m_out   = '0;
        end else if (!enable) begin
            m_phase = 0;
            m_wsh   = int'(wave_sel);
            m_vsh   = int'(volume);
            if (sample_req) begin
                s.due = cyc + 3;
                s.val = '0;
                pend.push_back(s);
            end
        end else if (sample_req) begin
            sum = m_phase + longint'(freq_word);
            if (sum >= (64'd1 << 32)) begin
                m_wsh = int'(wave_sel);
                m_vsh = int'(volume);
            end
            m_phase = sum % (64'd1 << 32);
            v  = atten(shape(m_wsh, m_phase / 256), m_vsh);
            vb = v;
            s.due = cyc + 3;
            s.val = vb[23:0];
            pend.push_back(s);
        end
    endtask

    task automatic check_outputs();
        strobe_t s;
        logic    ev;
        ev = 1'b0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            s     = pend.pop_front();
            m_out = s.val;
            ev    = 1'b1;
        end
        check("valid", {31'b0, sample_valid}, {31'b0, ev});
        check("out", {8'b0, sample_out}, {8'b0, m_out});
        if (sample_valid === 1'b1) begin
            seen.push_back(sample_out);
            seen_cyc.push_back(cyc);
        end
    endtask

    task automatic tick();
        model_apply();
        @(posedge sys_clk);
        #1;
        cyc++;
        check_outputs();
    endtask

    function automatic logic [31:0] sv(int i);
        if (i < seen.size()) return {8'b0, seen[i]};
        return 'x;
    endfunction

    function automatic int sc(int i);
        if (i < seen_cyc.size()) return seen_cyc[i];
        return -1000;
    endfunction

    int req_cyc;

    initial begin
        rst        = 1'b1;
        sample_req = 1'b1;
        enable     = 1'b0;
        freq_word  = '0;
        wave_sel   = 2'd0;
        volume     = 4'd0;

        // Reset held two cycles with requests pulsing.
        tick();
        tick();
        check("rst_valid", {31'b0, sample_valid}, 32'd0);
        check("rst_out", {8'b0, sample_out}, 32'd0);

        // Square: shadows loaded while disabled, then four requests.
        rst = 1'b0; sample_req = 1'b0; enable = 1'b0; wave_sel = 2'd0; volume = 4'd0;
        tick();
        seen.delete(); seen_cyc.delete();
        enable = 1'b1; freq_word = 32'h4000_0000; sample_req = 1'b1;
        req_cyc = cyc;
        repeat (4) tick();
        sample_req = 1'b0;
        repeat (4) tick();
        check("sq_lat", sc(0) - req_cyc, 32'd3);
        check("sq0", sv(0), 32'h7FFFFF);
        check("sq1", sv(1), 32'h800001);
        check("sq2", sv(2), 32'h800001);
        check("sq3", sv(3), 32'h7FFFFF);

        // Saw ramp, eighth request wraps to phase 0.
        enable = 1'b0; wave_sel = 2'd1;
        tick();
        seen.delete(); seen_cyc.delete();
        enable = 1'b1; freq_word = 32'h2000_0000; sample_req = 1'b1;
        repeat (8) tick();
        sample_req = 1'b0;
        repeat (4) tick();
        check("saw0", sv(0), 32'hA00000);
        check("saw7", sv(7), 32'h800000);

        // Triangle with one bit of attenuation.
        enable = 1'b0; wave_sel = 2'd2; volume = 4'd1;
        tick();
        seen.delete(); seen_cyc.delete();
        enable = 1'b1; freq_word = 32'h4000_0000; sample_req = 1'b1;
        repeat (2) tick();
        sample_req = 1'b0;
        repeat (4) tick();
        check("tri0", sv(0), 32'h000000);
        check("tri1", sv(1), 32'h3FFFFF);

        // Waveform change only takes effect at the wrap.
        enable = 1'b0; wave_sel = 2'd1; volume = 4'd0;
        tick();
        seen.delete(); seen_cyc.delete();
        enable = 1'b1; freq_word = 32'h4000_0000; sample_req = 1'b1;
        tick();
        wave_sel = 2'd0;
        repeat (3) tick();
        sample_req = 1'b0;
        repeat (4) tick();
        check("shd0", sv(0), 32'hC00000);
        check("shd1", sv(1), 32'h000000);
        check("shd2", sv(2), 32'h400000);
        check("shd3", sv(3), 32'h7FFFFF);

        // Back-to-back requests; reset at N+4 drops the N+5 strobe.
        seen.delete(); seen_cyc.delete();
        req_cyc = cyc;
        sample_req = 1'b1;
        repeat (3) tick();
        sample_req = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (4) tick();
        check("thr_n", seen.size(), 32'd2);
        check("thr_c0", sc(0) - req_cyc, 32'd3);
        check("thr_c1", sc(1) - req_cyc, 32'd4);
        check("thr_v0", sv(0), 32'h7FFFFF);
        check("thr_v1", sv(1), 32'h800001);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            rst        = ($urandom_range(0, 99) == 0);
            enable     = ($urandom_range(0, 9) != 0);
            sample_req = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 15) == 0) begin
                case ($urandom_range(0, 3))
                    0: freq_word = $urandom;
                    1: freq_word = $urandom_range(0, 255) << 24;
                    2: freq_word = 32'hFFFF_FFFF - $urandom_range(0, 3);
                    default: freq_word = '0;
                endcase
            end
            if ($urandom_range(0, 7) == 0) wave_sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) volume = 4'($urandom_range(0, 15));
            tick();
        end
        rst = 1'b0; sample_req = 1'b0;
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tone_gen.md
# tone_gen

Phase-accumulator tone source for the DE2 audio path. It produces one signed 24-bit sample per request from the I2S DAC codec stage, and its `sample_out` drives the codec's left/right data inputs. It replaces the free-running square generator with a request-driven, glitch-free source:
- selectable waveform (square, sawtooth, triangle, silence)
- per-request frequency word
- shift-based volume control

## Interface
Parameters:
- `PHASE_W`, 32: phase accumulator width; output frequency = `freq_word * f_req / 2^PHASE_W`.
- `SAMPLE_W`, 24: output sample width, two's complement. `PHASE_W` must be ≥ `SAMPLE_W`.

Ports (reset is synchronous, active-high):
- `sys_clk`  in  1  system clock (50 MHz on DE2).
- `rst`  in  1  synchronous, active-high reset.
- `sample_req`  in  1  one-cycle pulse from the codec; one pulse requests one new sample. Back-to-back pulses are legal.
- `enable`  in  1  0 = hold phase at 0 and output silence.
- `freq_word`  in  `PHASE_W`  phase increment, sampled on every `sample_req`.
- `wave_sel`  in  2  waveform select: 0 square, 1 saw, 2 triangle, 3 silence.
- `volume`  in  4  attenuation as an arithmetic right shift of 0..15 bits.
- `sample_out`  out  `SAMPLE_W`  signed sample; holds its value between valid strobes.
- `sample_valid`  out  1  one-cycle strobe; `sample_out` is new in that cycle.

## Operation
- **Shadow registers.** `wave_sh` and `vol_sh` hold the waveform and volume actually used.
  - While `enable`=0 they load `wave_sel`/`volume` every cycle.
  - While `enable`=1 they load only on a phase wrap, so a change never cuts a period short.
- **Stage 1 (accumulate).** Runs on each `sample_req`.
  - `enable`=1: phase ← (phase + `freq_word`) mod 2^`PHASE_W`. Wrap = carry out of that add. On wrap, the shadows load the current inputs, and the new values travel with the wrapped phase.
  - `enable`=0: phase ← 0, and the sample is forced to silence.
  - Stage 1 registers phase, `wave_sh`, `vol_sh` and a valid bit.
- **Stage 2 (shape).** Let t = phase[`PHASE_W`-1 -: `SAMPLE_W`].
  - Square: t[MSB]=0 → 0x7FFFFF, else 0x800001 (symmetric ±(2^23−1)).
  - Saw: {~t[MSB], t[MSB-1:0]}. This is a ramp from −2^23 to 2^23−1.
  - Triangle: u = t[MSB] ? ~t[MSB-1:0] : t[MSB-1:0]. Output = {u,1'b0} XOR 0x800000. Range is −2^23 to 2^23−2.
  - Silence, or disabled sample: 0.
- **Stage 3 (attenuate).** `sample_out` ← shaped value >>> `vol_sh` (sign-extending), and `sample_valid` ← stage-2 valid bit.
  - Negative values never round up to 0 (shift semantics), so −1 stays −1.
- **No overflow.** All arithmetic fits in `SAMPLE_W`. `freq_word`=0 gives a constant output at the current phase.
- **Reset values.** phase 0, `wave_sh`=3 (silence), `vol_sh`=0, all pipeline valid bits 0, `sample_out`=0, `sample_valid`=0.

## Timing
- `sample_req` high in cycle N → `sample_valid` high in cycle N+3 only, with `sample_out` updated on that same edge.
- Fully pipelined: one request per cycle is sustained, and each request yields exactly one strobe, in order.
- `sample_req` while `rst`=1 is ignored.
- `rst` asserted mid-pipeline discards in-flight samples. No strobe appears for requests made at N−2..N, where N is the reset cycle.
- `freq_word` change takes effect on the next request. `wave_sel`/`volume` changes take effect on the first wrapped sample, or immediately while disabled.
- Simultaneous wrap and input change in the same request cycle: the new inputs are used.
- `enable` falling: from the next request, the output is 0 and the phase restarts from 0 on re-enable.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- **Reset:** hold `rst` 2 cycles while pulsing `sample_req` → `sample_valid`=0 and `sample_out`=0 throughout. The first request after reset gives valid 3 cycles later.
- **Square:** load `wave_sel`=0, `volume`=0 with `enable`=0, then set `enable`=1 and `freq_word`=0x40000000, and issue 4 requests → outputs 0x7FFFFF, 0x800001, 0x800001, 0x7FFFFF.
- **Saw:** `wave_sel`=1, `freq_word`=0x20000000, first request → 0xA00000. Eighth request (phase wraps to 0) → 0x800000.
- **Triangle with volume:** `wave_sel`=2, `volume`=1, `freq_word`=0x40000000 → outputs 0x000000, then 0x3FFFFF.
- **Shadow timing:** while running saw at `freq_word`=0x40000000, switch `wave_sel` to 0 after the first request. Samples 2–3 remain saw; sample 4 (wrap, phase 0) → 0x7FFFFF.
- **Throughput:** `sample_req` high for 3 consecutive cycles N..N+2 → `sample_valid` high at N+3..N+5, with successive phase values. Asserting `rst` at N+4 suppresses the N+5 strobe.
